hazard_stall_unit: RTL and testbench

- Producer of Stall_Data_Hazard for the non-forwarding 5-stage MIPS pipeline. The control decoder consumes this signal and zeroes all control outputs (a bubble) while it is high.
- Keeps its own scoreboard of in-flight destination registers for EX, MEM and WB.
- Compares the source registers of the instruction in ID against the scoreboard and holds PC and IF/ID until the producer has retired.
- Also drives PCWrite / IFIDWrite and a saturating stall-cycle statistic.

---
 rtl/hazard_stall_unit.sv | 156 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Data-hazard stall generator for a 5-stage MIPS pipeline with no forwarding.
// A private three-entry scoreboard (EX, MEM, WB) records the destination
// register of every instruction that left ID. The instruction currently in ID
// is compared against it. A match on a used, nonzero source register holds PC
// and IF/ID and asks the control decoder for a bubble. The hold lasts until
// the producer has moved far enough down the pipe.
//
// Parameters
//   WB_SPLIT  1: the register file writes in the first half-cycle and reads in
//                the second, so a producer in WB is already readable.
//             0: the WB entry is checked as well.
//   CNT_W     width of the saturating stall_count statistic.
//
// Ports
//   clk                pipeline clock, rising edge
//   reset              asynchronous, active-high
//   id_opcode          opcode field of the instruction in ID
//   id_rs, id_rt       source register fields of the instruction in ID
//   id_dest            destination selected in ID (rd or rt)
//   id_reg_write       RegWrite from the decoder, before stall gating
//   flush              the ID instruction is squashed this cycle
//   Stall_Data_Hazard  insert a bubble (decoder zeroes its controls)
//   PCWrite            PC update enable
//   IFIDWrite          IF/ID load enable
//   stall_count        stall cycles since reset, saturating at all-ones
//
// Hold protocol: the ID instruction counts as "accepted" on a rising clk
// where Stall_Data_Hazard is low. While the stall is high, PC and IF/ID keep
// their values, so the same instruction is presented again next cycle. A
// bubble enters EX in its place. A flushed instruction is never held: it is
// replaced by a bubble in the same edge.
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter bit WB_SPLIT = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_reg_write,
  input  logic             flush,
  output logic             Stall_Data_Hazard,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic [CNT_W-1:0] stall_count
);

  // Opcodes that change which fields are real source operands.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_entry_t;

  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;
  sb_entry_t ex_d;

  logic rs_used;
  logic rt_used;
  logic rs_hazard;
  logic rt_hazard;
  logic hazard;
  logic stall;

  // True when a valid in-flight entry will write the register src.
  // $0 is filtered on both sides, so a stray zero dest can never stall.
  function automatic logic entry_hits(input sb_entry_t e, input logic [4:0] src);
    return e.valid && (e.dest != 5'd0) && (src != 5'd0) && (e.dest == src);
  endfunction

  // Source-operand decode. rs is read by everything except j. rt is a
  // source only for R-type, sw (store data) and beq (compare operand).
  // lw, addi and unknown opcodes use rt as a destination or not at all.
  always_comb begin
    rs_used = (id_opcode != OP_J);
    rt_used = 1'b0;
    case (id_opcode)
      OP_RTYPE: rt_used = 1'b1;
      OP_SW:    rt_used = 1'b1;
      OP_BEQ:   rt_used = 1'b1;
      default:  rt_used = 1'b0;
    endcase
  end

  // The WB entry is only a hazard when the register file cannot bypass
  // a same-cycle write to a read.
  always_comb begin
    rs_hazard = 1'b0;
    rt_hazard = 1'b0;
    if (rs_used) begin
      rs_hazard = entry_hits(ex_q, id_rs) || entry_hits(mem_q, id_rs) ||
                  (!WB_SPLIT && entry_hits(wb_q, id_rs));
    end
    if (rt_used) begin
      rt_hazard = entry_hits(ex_q, id_rt) || entry_hits(mem_q, id_rt) ||
                  (!WB_SPLIT && entry_hits(wb_q, id_rt));
    end
    hazard = rs_hazard || rt_hazard;
  end

  // A flush wins over a hazard. The squashed instruction will not execute,
  // so holding it would only waste cycles. Reset also forces the stall low
  // combinationally, so the outputs are clean while reset is asserted.
  assign stall             = hazard && !flush && !reset;
  assign Stall_Data_Hazard = stall;
  assign PCWrite           = !stall;
  assign IFIDWrite         = !stall;

  // Entry for the instruction leaving ID this edge. A stalled or flushed
  // instruction becomes a bubble. Writes to $0 are dropped here, so they
  // never occupy a slot.
  always_comb begin
    ex_d       = '0;
    ex_d.dest  = id_dest;
    ex_d.valid = id_reg_write && (id_dest != 5'd0) && !stall && !flush;
  end

  // Scoreboard shift: one stage per clock, mirroring the pipeline itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  // Stall statistic. It stops at all-ones instead of wrapping, so a long
  // run never reads back as a small number.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Three instances share clock and reset and have independent ID inputs:
//   idx 0: WB_SPLIT=1, CNT_W=16
//   idx 1: WB_SPLIT=0, CNT_W=16
//   idx 2: WB_SPLIT=1, CNT_W=4   (saturation)
// The reference model records, per register, the last cycle in which a
// reader would still see a stale value. An issued writer is readable
// 2 (WB_SPLIT=1) or 3 (WB_SPLIT=0) cycles after it leaves ID.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  typedef struct {
    logic [5:0] op;
    logic [4:0] s;
    logic [4:0] t;
    logic [4:0] d;
    logic       w;
  } instr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [5:0] opc [3];
  logic [4:0] rs  [3];
  logic [4:0] rt  [3];
  logic [4:0] dst [3];
  logic       rw  [3];
  logic       fl  [3];
  logic       stall [3];
  logic       pcw   [3];
  logic       ifw   [3];
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
  logic [3:0]  cnt_c;

  hazard_stall_unit #(.WB_SPLIT(1'b1), .CNT_W(16)) u_split (
    .clk(clk), .reset(rst), .id_opcode(opc[0]), .id_rs(rs[0]), .id_rt(rt[0]),
    .id_dest(dst[0]), .id_reg_write(rw[0]), .flush(fl[0]),
    .Stall_Data_Hazard(stall[0]), .PCWrite(pcw[0]), .IFIDWrite(ifw[0]),
    .stall_count(cnt_a));

  hazard_stall_unit #(.WB_SPLIT(1'b0), .CNT_W(16)) u_nosplit (
    .clk(clk), .reset(rst), .id_opcode(opc[1]), .id_rs(rs[1]), .id_rt(rt[1]),
    .id_dest(dst[1]), .id_reg_write(rw[1]), .flush(fl[1]),
    .Stall_Data_Hazard(stall[1]), .PCWrite(pcw[1]), .IFIDWrite(ifw[1]),
    .stall_count(cnt_b));

  hazard_stall_unit #(.WB_SPLIT(1'b1), .CNT_W(4)) u_small (
    .clk(clk), .reset(rst), .id_opcode(opc[2]), .id_rs(rs[2]), .id_rt(rt[2]),
    .id_dest(dst[2]), .id_reg_write(rw[2]), .flush(fl[2]),
    .Stall_Data_Hazard(stall[2]), .PCWrite(pcw[2]), .IFIDWrite(ifw[2]),
    .stall_count(cnt_c));

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];   // expected stall lengths of directed consumers

  // ---------------- reference model ----------------
  int busy [3][32];        // last cycle in which register r is still stale
  int cyc  [3];
  int mcnt [3];
  int lat  [3] = '{2, 3, 2};
  int cmax [3] = '{65535, 65535, 15};

  function automatic bit uses_rs(logic [5:0] op);
    return op != 6'b000010;
  endfunction

  function automatic bit uses_rt(logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100);
  endfunction

  function automatic bit model_stall(int i);
    bit h;
    h = 1'b0;
    if (rst || fl[i]) return 1'b0;
    if (uses_rs(opc[i]) && rs[i] != 0 && cyc[i] <= busy[i][rs[i]]) h = 1'b1;
    if (uses_rt(opc[i]) && rt[i] != 0 && cyc[i] <= busy[i][rt[i]]) h = 1'b1;
    return h;
  endfunction

  function automatic int get_cnt(int i);
    case (i)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cyc[i]  = 0;
        mcnt[i] = 0;
        for (int r = 0; r < 32; r++) busy[i][r] = -100;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit s;
        s = model_stall(i);
        if (s && mcnt[i] < cmax[i]) mcnt[i]++;
        if (!s && !fl[i] && rw[i] && dst[i] != 0) busy[i][dst[i]] = cyc[i] + lat[i];
        cyc[i]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_nop(int i);
    opc[i] = 6'd0; rs[i] = 5'd0; rt[i] = 5'd0; dst[i] = 5'd0;
    rw[i] = 1'b0; fl[i] = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) set_nop(i);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < 3; i++) set_nop(i);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one instruction in ID on instance i and follows the DUT's
  // hold until it is accepted. It reports the observed and modelled stall
  // cycles, per-cycle stall disagreements, PCWrite/IFIDWrite cycles that
  // disagree with the stall, and whether the cycle budget ran out.
  task automatic run_instr(input int i, input instr_t ins, input logic f,
                           output int obs, output int mdl, output int diff,
                           output int pcbad, output bit timeout);
    bit ms;
    logic ds;
    bit done;
    obs = 0; mdl = 0; diff = 0; pcbad = 0; done = 1'b0;
    opc[i] = ins.op; rs[i] = ins.s; rt[i] = ins.t; dst[i] = ins.d;
    rw[i] = ins.w; fl[i] = f;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ms = model_stall(i);
      ds = stall[i];
      if (ms) mdl++;
      if (ds === 1'b1) obs++;
      if (ds !== logic'(ms)) diff++;
      if (pcw[i] !== !ds || ifw[i] !== !ds) pcbad++;
      @(posedge clk);
      #1;
      if (ds === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    timeout = !done;
    set_nop(i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_nop(i);
      opc[i] = 6'd0; rs[i] = 5'd3; rt[i] = 5'd3; dst[i] = 5'd3; rw[i] = 1'b1;
    end
    #3;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (stall[i] !== 1'b0 || pcw[i] !== 1'b1 || ifw[i] !== 1'b1 || get_cnt(i) !== 0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: stall=%b pcw=%b ifw=%b cnt=%0d, need 0/1/1/0",
                 i, stall[i], pcw[i], ifw[i], get_cnt(i));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) set_nop(i);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (stall[i] !== 1'b0 || pcw[i] !== 1'b1 || ifw[i] !== 1'b1 || get_cnt(i) !== 0) begin
        n_err++;
        $display("FAIL reset_release[%0d]: stall=%b pcw=%b ifw=%b cnt=%0d, need 0/1/1/0",
                 i, stall[i], pcw[i], ifw[i], get_cnt(i));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    instr_t add3, sub4;
    int obs, mdl, diff, pcbad, cnt;
    bit to;
    logic [7:0] e;
    add3 = '{6'h00, 5'd1, 5'd2, 5'd3, 1'b1};
    sub4 = '{6'h00, 5'd5, 5'd3, 5'd4, 1'b1};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      exp_q.push_back((i == 0) ? 8'd2 : 8'd3);
      run_instr(i, add3, 1'b0, obs, mdl, diff, pcbad, to);
      run_instr(i, sub4, 1'b0, obs, mdl, diff, pcbad, to);
      e = exp_q.pop_front();
      cnt = get_cnt(i);
      n_cmp++;
      if (obs !== int'(e) || diff != 0 || to) begin
        n_err++;
        $display("FAIL b2b_len[%0d]: stalls=%0d model=%0d diff=%0d timeout=%0b, need %0d",
                 i, obs, mdl, diff, to, e);
      end
      n_cmp++;
      if (pcbad != 0) begin
        n_err++;
        $display("FAIL b2b_pcwrite[%0d]: %0d bad cycles, need 0", i, pcbad);
      end
      n_cmp++;
      if (cnt !== int'(e) || cnt != mcnt[i]) begin
        n_err++;
        $display("FAIL b2b_count[%0d]: stall_count=%0d, need %0d", i, cnt, e);
      end
    end
  endtask

  task automatic test_usage();
    instr_t prod [7];
    instr_t cons [7];
    int exp_u [7];
    int obs, mdl, diff, pcbad;
    bit to;
    prod[0] = '{6'h23, 5'd9, 5'd8, 5'd8, 1'b1};  cons[0] = '{6'h2b, 5'd10, 5'd8, 5'd0, 1'b0};  exp_u[0] = 2;
    prod[1] = '{6'h23, 5'd9, 5'd8, 5'd8, 1'b1};  cons[1] = '{6'h08, 5'd8, 5'd11, 5'd11, 1'b1}; exp_u[1] = 2;
    prod[2] = '{6'h23, 5'd9, 5'd8, 5'd8, 1'b1};  cons[2] = '{6'h08, 5'd1, 5'd8, 5'd8, 1'b1};   exp_u[2] = 0;
    prod[3] = '{6'h08, 5'd1, 5'd0, 5'd0, 1'b1};  cons[3] = '{6'h00, 5'd0, 5'd0, 5'd2, 1'b1};   exp_u[3] = 0;
    prod[4] = '{6'h00, 5'd1, 5'd2, 5'd3, 1'b1};  cons[4] = '{6'h02, 5'd3, 5'd3, 5'd0, 1'b0};   exp_u[4] = 0;
    prod[5] = '{6'h23, 5'd9, 5'd8, 5'd8, 1'b1};  cons[5] = '{6'h3f, 5'd1, 5'd8, 5'd0, 1'b0};   exp_u[5] = 0;
    prod[6] = '{6'h00, 5'd1, 5'd2, 5'd3, 1'b1};  cons[6] = '{6'h04, 5'd5, 5'd3, 5'd0, 1'b0};   exp_u[6] = 2;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      run_instr(0, prod[k], 1'b0, obs, mdl, diff, pcbad, to);
      run_instr(0, cons[k], 1'b0, obs, mdl, diff, pcbad, to);
      n_cmp++;
      if (obs != exp_u[k] || diff != 0 || pcbad != 0 || to) begin
        n_err++;
        $display("FAIL usage[%0d]: stalls=%0d diff=%0d pcbad=%0d timeout=%0b, need %0d",
                 k, obs, diff, pcbad, to, exp_u[k]);
      end
      idle(4);
    end
  endtask

  task automatic test_gap();
    instr_t add3, other, beq;
    int obs, mdl, diff, pcbad;
    bit to;
    add3  = '{6'h00, 5'd1, 5'd2, 5'd3, 1'b1};
    other = '{6'h00, 5'd1, 5'd2, 5'd6, 1'b1};
    beq   = '{6'h04, 5'd3, 5'd4, 5'd0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      run_instr(i, add3, 1'b0, obs, mdl, diff, pcbad, to);
      run_instr(i, other, 1'b0, obs, mdl, diff, pcbad, to);
      run_instr(i, beq, 1'b0, obs, mdl, diff, pcbad, to);
      n_cmp++;
      if (obs != ((i == 0) ? 1 : 2) || diff != 0 || pcbad != 0 || to) begin
        n_err++;
        $display("FAIL gap[%0d]: stalls=%0d diff=%0d pcbad=%0d timeout=%0b, need %0d",
                 i, obs, diff, pcbad, to, (i == 0) ? 1 : 2);
      end
    end
  endtask

  task automatic test_flush();
    instr_t add3, sub4, use4;
    int obs, mdl, diff, pcbad;
    bit to;
    add3 = '{6'h00, 5'd1, 5'd2, 5'd3, 1'b1};
    sub4 = '{6'h00, 5'd3, 5'd5, 5'd4, 1'b1};
    use4 = '{6'h00, 5'd4, 5'd4, 5'd7, 1'b1};
    do_reset();
    run_instr(0, add3, 1'b0, obs, mdl, diff, pcbad, to);
    run_instr(0, sub4, 1'b1, obs, mdl, diff, pcbad, to);
    n_cmp++;
    if (obs != 0 || diff != 0 || pcbad != 0 || to) begin
      n_err++;
      $display("FAIL flush_priority: stalls=%0d diff=%0d pcbad=%0d, need 0", obs, diff, pcbad);
    end
    run_instr(0, use4, 1'b0, obs, mdl, diff, pcbad, to);
    n_cmp++;
    if (obs != 0 || diff != 0 || to) begin
      n_err++;
      $display("FAIL flush_bubble: stalls=%0d diff=%0d, need 0 (flushed dest must not stall)",
               obs, diff);
    end
  endtask

  task automatic test_random();
    logic [5:0] op_tbl [8];
    instr_t ins;
    int obs, mdl, diff, pcbad;
    int tdiff, tpc, tto, total;
    bit to;
    logic f;
    op_tbl = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h3f, 6'h0f};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      tdiff = 0; tpc = 0; tto = 0; total = 0;
      for (int k = 0; k < 80; k++) begin
        ins.op = op_tbl[$urandom_range(7, 0)];
        ins.s  = 5'($urandom_range(7, 0));
        ins.t  = 5'($urandom_range(7, 0));
        ins.d  = 5'($urandom_range(7, 0));
        ins.w  = 1'($urandom_range(1, 0));
        f      = ($urandom_range(7, 0) == 0);
        run_instr(i, ins, f, obs, mdl, diff, pcbad, to);
        tdiff += diff; tpc += pcbad; tto += int'(to); total += obs;
      end
      n_cmp++;
      if (tdiff != 0 || tto != 0) begin
        n_err++;
        $display("FAIL random_stall[%0d]: %0d disagreeing cycles, %0d timeouts, need 0", i, tdiff, tto);
      end
      n_cmp++;
      if (tpc != 0) begin
        n_err++;
        $display("FAIL random_pcwrite[%0d]: %0d bad cycles, need 0", i, tpc);
      end
      n_cmp++;
      if (get_cnt(i) != mcnt[i] || get_cnt(i) != total) begin
        n_err++;
        $display("FAIL random_count[%0d]: stall_count=%0d, need %0d", i, get_cnt(i), mcnt[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    instr_t add3;
    int obs, mdl, diff, pcbad;
    bit to;
    add3 = '{6'h00, 5'd1, 5'd2, 5'd3, 1'b1};
    do_reset();
    run_instr(0, add3, 1'b0, obs, mdl, diff, pcbad, to);
    opc[0] = 6'h00; rs[0] = 5'd3; rt[0] = 5'd5; dst[0] = 5'd4; rw[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall[0] !== 1'b1 || pcw[0] !== 1'b0 || ifw[0] !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_pre: stall=%b pcw=%b ifw=%b, need 1/0/0", stall[0], pcw[0], ifw[0]);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (cnt_a !== 16'd1 || stall[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_count_pre: cnt=%0d stall=%b, need 1/1", cnt_a, stall[0]);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (stall[0] !== 1'b0 || pcw[0] !== 1'b1 || ifw[0] !== 1'b1 || cnt_a !== 16'd0) begin
      n_err++;
      $display("FAIL midrst_async: stall=%b pcw=%b ifw=%b cnt=%0d, need 0/1/1/0",
               stall[0], pcw[0], ifw[0], cnt_a);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (stall[0] !== 1'b0 || pcw[0] !== 1'b1 || cnt_a !== 16'd0 || model_stall(0)) begin
      n_err++;
      $display("FAIL midrst_cleared: stall=%b pcw=%b cnt=%0d, need 0/1/0", stall[0], pcw[0], cnt_a);
    end
    @(posedge clk);
    #1;
    set_nop(0);
  endtask

  task automatic test_saturation();
    instr_t add3, sub4;
    int obs, mdl, diff, pcbad, total, want;
    bit to;
    add3 = '{6'h00, 5'd1, 5'd2, 5'd3, 1'b1};
    sub4 = '{6'h00, 5'd3, 5'd5, 5'd4, 1'b0};
    do_reset();
    total = 0;
    for (int k = 1; k <= 10; k++) begin
      run_instr(2, add3, 1'b0, obs, mdl, diff, pcbad, to);
      run_instr(2, sub4, 1'b0, obs, mdl, diff, pcbad, to);
      total += obs;
      want = (2 * k > 15) ? 15 : 2 * k;
      n_cmp++;
      if (int'(cnt_c) != want || obs != 2 || to) begin
        n_err++;
        $display("FAIL saturate[%0d]: cnt=%0d stalls=%0d, need cnt %0d stalls 2", k, cnt_c, obs, want);
      end
    end
    n_cmp++;
    if (total != 20 || cnt_c !== 4'd15) begin
      n_err++;
      $display("FAIL saturate_final: total=%0d cnt=%0d, need 20 and 15", total, cnt_c);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  // ---------------- sequence ----------------
  initial begin
    for (int i = 0; i < 3; i++) set_nop(i);
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_usage();
    test_gap();
    test_flush();
    test_random();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
